// File: rtl/alu_control_mdu_pkg.sv
// Shared definitions for alu_control_mdu: ALU control codes, R-type funct codes,
// the multiply/divide sequencer states and the decoded multiply/divide request.
package alu_control_mdu_pkg;

    localparam logic [3:0] ALU_AND     = 4'b0000,
                           ALU_OR      = 4'b0001,
                           ALU_ADD     = 4'b0010,
                           ALU_SUB     = 4'b0110,
                           ALU_SLT     = 4'b0111,
                           ALU_NOR     = 4'b1100,
                           ALU_INVALID = 4'b1111;

    localparam logic [5:0] FN_ADD   = 6'b100000,
                           FN_SUB   = 6'b100010,
                           FN_AND   = 6'b100100,
                           FN_OR    = 6'b100101,
                           FN_SLT   = 6'b101010,
                           FN_NOR   = 6'b100111,
                           FN_MULT  = 6'b011000,
                           FN_MULTU = 6'b011001,
                           FN_DIV   = 6'b011010,
                           FN_DIVU  = 6'b011011,
                           FN_MFHI  = 6'b010000,
                           FN_MTHI  = 6'b010001,
                           FN_MFLO  = 6'b010010,
                           FN_MTLO  = 6'b010011;

    typedef logic [1:0] md_state_t;
    localparam md_state_t ST_IDLE = 2'd0,
                          ST_BUSY = 2'd1,
                          ST_FIX  = 2'd2;

    typedef enum logic [2:0] {
        MD_NONE, MD_MUL, MD_DIV, MD_MTHI, MD_MTLO, MD_MFHI, MD_MFLO
    } md_op_e;

    typedef struct packed {
        md_op_e op;
        logic   sgn;
    } md_dec_t;

endpackage

// File: rtl/alu_control_mdu_iter.sv
// Iterative multiply/divide datapath: one shift-add or restoring shift-subtract step
// per cycle on operand magnitudes, sign-corrected results. Divider only with ALU_CONTROL_MDU_DIV_EN.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             step_i,
    input  logic             signed_i,
`ifdef ALU_CONTROL_MDU_DIV_EN
    input  logic             div_i,
    output logic             div_zero_o,
`endif
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int W2 = 2 * WIDTH;

    logic [W2-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             neg_lo_q, neg_lo_d;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [W2-1:0]    mul_next, product;

    assign mag_a = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
    assign mag_b = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    assign product  = neg_lo_q ? -acc_q : acc_q;

`ifdef ALU_CONTROL_MDU_DIV_EN
    logic             neg_hi_q, neg_hi_d;
    logic             div_q, div_d;
    logic [WIDTH:0]   div_r, div_diff;
    logic [W2-1:0]    div_next;

    assign div_zero_o = div_i && (b_i == '0);

    // Divide: acc = {remainder, dividend bits shifting out / quotient bits shifting in}.
    assign div_r    = acc_q[W2-1:WIDTH-1];
    assign div_diff = div_r - {1'b0, b_q};
    assign div_next = div_diff[WIDTH] ? {div_r[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    always_comb begin
        hi_o = product[W2-1:WIDTH];
        lo_o = product[WIDTH-1:0];
        if (div_q) begin
            hi_o = neg_hi_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
            lo_o = neg_lo_q ? -acc_q[WIDTH-1:0]  : acc_q[WIDTH-1:0];
        end
    end
`else
    assign hi_o = product[W2-1:WIDTH];
    assign lo_o = product[WIDTH-1:0];
`endif

    always_comb begin
        acc_d    = acc_q;
        b_d      = b_q;
        neg_lo_d = neg_lo_q;
`ifdef ALU_CONTROL_MDU_DIV_EN
        neg_hi_d = neg_hi_q;
        div_d    = div_q;
`endif
        if (start_i) begin
            acc_d    = {{WIDTH{1'b0}}, mag_a};
            b_d      = mag_b;
            neg_lo_d = signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
`ifdef ALU_CONTROL_MDU_DIV_EN
            div_d    = div_i;
            neg_hi_d = signed_i && a_i[WIDTH-1];
            // Divide by zero preloads the final answer; no steps follow.
            if (div_zero_o) begin
                acc_d    = {a_i, {WIDTH{1'b1}}};
                neg_lo_d = 1'b0;
                neg_hi_d = 1'b0;
            end
`endif
        end else if (step_i) begin
`ifdef ALU_CONTROL_MDU_DIV_EN
            acc_d = div_q ? div_next : mul_next;
`else
            acc_d = mul_next;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            b_q      <= '0;
            neg_lo_q <= 1'b0;
`ifdef ALU_CONTROL_MDU_DIV_EN
            neg_hi_q <= 1'b0;
            div_q    <= 1'b0;
`endif
        end else begin
            acc_q    <= acc_d;
            b_q      <= b_d;
            neg_lo_q <= neg_lo_d;
`ifdef ALU_CONTROL_MDU_DIV_EN
            neg_hi_q <= neg_hi_d;
            div_q    <= div_d;
`endif
        end
    end

endmodule

// File: rtl/alu_control_mdu.sv
// ALU control decoder with an attached multi-cycle multiply/divide unit and HI/LO registers.
// Define ALU_CONTROL_MDU_DIV_EN to include DIV/DIVU; otherwise they decode as illegal.
module alu_control_mdu
    import alu_control_mdu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inm,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    input  logic [CTRL_W-1:0] alu_op_final,
    input  logic              issue,
    input  logic [WIDTH-1:0]  rs_val,
    input  logic [WIDTH-1:0]  rt_val,
    output logic [CTRL_W-1:0] control,
    output logic              illegal,
    output logic              md_busy,
    output logic              stall,
    output logic [WIDTH-1:0]  hilo_data,
    output logic              hilo_valid
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    md_dec_t          dec;
    logic             md_req, md_go, md_start, md_step, div_zero;
    logic [WIDTH-1:0] res_hi, res_lo;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        control = CTRL_W'(ALU_INVALID);
        illegal = 1'b0;
        dec.op  = MD_NONE;
        dec.sgn = 1'b0;
        if (inm) begin
            control = alu_op_final;
        end else begin
            case (alu_op)
                2'b00: control = CTRL_W'(ALU_ADD);
                2'b01: control = CTRL_W'(ALU_SUB);
                2'b11: begin
                    control = CTRL_W'(ALU_AND);
                    illegal = 1'b1;
                end
                default: begin
                    case (funct)
                        FN_ADD:   control = CTRL_W'(ALU_ADD);
                        FN_SUB:   control = CTRL_W'(ALU_SUB);
                        FN_AND:   control = CTRL_W'(ALU_AND);
                        FN_OR:    control = CTRL_W'(ALU_OR);
                        FN_SLT:   control = CTRL_W'(ALU_SLT);
                        FN_NOR:   control = CTRL_W'(ALU_NOR);
                        FN_MULT:  begin control = CTRL_W'(ALU_AND); dec.op = MD_MUL; dec.sgn = 1'b1; end
                        FN_MULTU: begin control = CTRL_W'(ALU_AND); dec.op = MD_MUL; end
`ifdef ALU_CONTROL_MDU_DIV_EN
                        FN_DIV:   begin control = CTRL_W'(ALU_AND); dec.op = MD_DIV; dec.sgn = 1'b1; end
                        FN_DIVU:  begin control = CTRL_W'(ALU_AND); dec.op = MD_DIV; end
`endif
                        FN_MFHI:  begin control = CTRL_W'(ALU_AND); dec.op = MD_MFHI; end
                        FN_MTHI:  begin control = CTRL_W'(ALU_AND); dec.op = MD_MTHI; end
                        FN_MFLO:  begin control = CTRL_W'(ALU_AND); dec.op = MD_MFLO; end
                        FN_MTLO:  begin control = CTRL_W'(ALU_AND); dec.op = MD_MTLO; end
                        default:  illegal = 1'b1;
                    endcase
                end
            endcase
        end
    end

    // An MD instruction arriving while the sequencer is occupied is held, then executes in IDLE.
    assign md_req     = issue && (dec.op != MD_NONE);
    assign stall      = md_req && (state_q != ST_IDLE);
    assign md_go      = md_req && (state_q == ST_IDLE) && !reset;
    assign md_busy    = (state_q != ST_IDLE);
    assign hilo_valid = md_go && (dec.op == MD_MFHI || dec.op == MD_MFLO);
    assign hilo_data  = !md_go               ? '0   :
                        (dec.op == MD_MFHI)  ? hi_q :
                        (dec.op == MD_MFLO)  ? lo_q : '0;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        md_start = 1'b0;
        md_step  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (md_go) begin
                    case (dec.op)
                        MD_MUL, MD_DIV: begin
                            md_start = 1'b1;
                            if (div_zero) begin
                                state_d = ST_FIX;
                            end else begin
                                state_d = ST_BUSY;
                                cnt_d   = CNT_W'(WIDTH);
                            end
                        end
                        MD_MTHI: hi_d = rs_val;
                        MD_MTLO: lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                md_step = 1'b1;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
            end
            ST_FIX: begin
                hi_d    = res_hi;
                lo_d    = res_lo;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    mdu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk        (clk),
        .reset      (reset),
        .start_i    (md_start),
        .step_i     (md_step),
        .signed_i   (dec.sgn),
`ifdef ALU_CONTROL_MDU_DIV_EN
        .div_i      (dec.op == MD_DIV),
        .div_zero_o (div_zero),
`endif
        .a_i        (rs_val),
        .b_i        (rt_val),
        .hi_o       (res_hi),
        .lo_o       (res_lo)
    );

`ifndef ALU_CONTROL_MDU_DIV_EN
    assign div_zero = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_alu_control_mdu.sv
// Self-checking bench for alu_control_mdu: decode table sweep, directed multi-cycle
// sequences and randomized MD traffic against a plain-arithmetic HI/LO model.
module tb_alu_control_mdu;

    localparam int WIDTH  = 32;
    localparam int CTRL_W = 4;

    localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001,
                           F_DIV  = 6'b011010, F_DIVU  = 6'b011011,
                           F_MFHI = 6'b010000, F_MTHI  = 6'b010001,
                           F_MFLO = 6'b010010, F_MTLO  = 6'b010011;

    logic              clk = 1'b0;
    logic              reset;
    logic              inm;
    logic [1:0]        alu_op;
    logic [5:0]        funct;
    logic [CTRL_W-1:0] alu_op_final;
    logic              issue;
    logic [WIDTH-1:0]  rs_val, rt_val;
    logic [CTRL_W-1:0] control;
    logic              illegal, md_busy, stall, hilo_valid;
    logic [WIDTH-1:0]  hilo_data;

    always #5 clk = ~clk;

    alu_control_mdu #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .inm          (inm),
        .alu_op       (alu_op),
        .funct        (funct),
        .alu_op_final (alu_op_final),
        .issue        (issue),
        .rs_val       (rs_val),
        .rt_val       (rt_val),
        .control      (control),
        .illegal      (illegal),
        .md_busy      (md_busy),
        .stall        (stall),
        .hilo_data    (hilo_data),
        .hilo_valid   (hilo_valid)
    );

    typedef struct {
        logic       inm;
        logic [1:0] alu_op;
        logic [5:0] funct;
        logic [3:0] fin;
        logic [3:0] e_ctrl;
        logic       e_ill;
    } vec_t;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_hi, m_lo;
    logic [3:0]  exp_ctrl [64];
    logic        exp_ill  [64];
    vec_t        vecs [$];
    logic [5:0]  md_fns [8] = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MTHI, F_MFLO, F_MTLO};
    logic [5:0]  r_fn;
    logic [31:0] r_a, r_b;
    int          n;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // HI/LO effect of one accepted MD instruction, in program order.
    task automatic model_apply(input logic [5:0] fn, input logic [31:0] rs, input logic [31:0] rt);
        longint a, b;
        case (fn)
            F_MULT:  {m_hi, m_lo} = longint'($signed(rs)) * longint'($signed(rt));
            F_MULTU: {m_hi, m_lo} = {32'd0, rs} * {32'd0, rt};
`ifdef ALU_CONTROL_MDU_DIV_EN
            F_DIV: begin
                if (rt == 0) begin
                    m_lo = 32'hFFFF_FFFF; m_hi = rs;
                end else begin
                    a = longint'($signed(rs)); b = longint'($signed(rt));
                    m_lo = 32'(a / b); m_hi = 32'(a % b);
                end
            end
            F_DIVU: begin
                if (rt == 0) begin
                    m_lo = 32'hFFFF_FFFF; m_hi = rs;
                end else begin
                    m_lo = rs / rt; m_hi = rs % rt;
                end
            end
`endif
            F_MTHI: m_hi = rs;
            F_MTLO: m_lo = rs;
            default: ;
        endcase
    endtask

    // Issue an R-type instruction at posedge+1, hold it while stalled, check the accepting cycle.
    task automatic issue_md(input string name, input logic [5:0] fn, input logic [31:0] rs, input logic [31:0] rt);
        logic [31:0] exp_data;
        logic        exp_valid;
        int          guard;
        exp_valid = (fn == F_MFHI) || (fn == F_MFLO);
        exp_data  = (fn == F_MFHI) ? m_hi : (fn == F_MFLO) ? m_lo : 32'd0;
        issue = 1'b1; inm = 1'b0; alu_op = 2'b10; funct = fn; rs_val = rs; rt_val = rt;
        #3;
        guard = 0;
        while (stall === 1'b1 && guard < 200) begin
            @(posedge clk); #4;
            guard++;
        end
        check({name, " stall_bound"}, 64'(guard < 200), 64'd1);
        check({name, " illegal"}, 64'(illegal), 64'(exp_ill[fn]));
        check({name, " hilo_valid"}, 64'(hilo_valid), 64'(exp_valid));
        check({name, " hilo_data"}, 64'(hilo_data), 64'(exp_data));
        model_apply(fn, rs, rt);
        @(posedge clk); #1;
        issue = 1'b0;
    endtask

    // Called at posedge+1; returns how many consecutive cycles md_busy stays high.
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (md_busy === 1'b1 && cycles < 100) begin
            cycles++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; issue = 1'b1; inm = 1'b0; alu_op = 2'b10; funct = F_MFHI;
        alu_op_final = '0; rs_val = 32'h1234; rt_val = 32'd3;
        m_hi = '0; m_lo = '0;

        for (int f = 0; f < 64; f++) begin
            exp_ctrl[f] = 4'b1111; exp_ill[f] = 1'b1;
        end
        exp_ctrl[6'b100000] = 4'b0010; exp_ill[6'b100000] = 1'b0;
        exp_ctrl[6'b100010] = 4'b0110; exp_ill[6'b100010] = 1'b0;
        exp_ctrl[6'b100100] = 4'b0000; exp_ill[6'b100100] = 1'b0;
        exp_ctrl[6'b100101] = 4'b0001; exp_ill[6'b100101] = 1'b0;
        exp_ctrl[6'b101010] = 4'b0111; exp_ill[6'b101010] = 1'b0;
        exp_ctrl[6'b100111] = 4'b1100; exp_ill[6'b100111] = 1'b0;
        foreach (md_fns[k]) begin
            exp_ctrl[md_fns[k]] = 4'b0000; exp_ill[md_fns[k]] = 1'b0;
        end
`ifndef ALU_CONTROL_MDU_DIV_EN
        exp_ctrl[F_DIV]  = 4'b1111; exp_ill[F_DIV]  = 1'b1;
        exp_ctrl[F_DIVU] = 4'b1111; exp_ill[F_DIVU] = 1'b1;
`endif

        // Reset holds everything quiet even with an MD instruction presented.
        #2;
        check("rst md_busy", 64'(md_busy), 64'd0);
        check("rst stall", 64'(stall), 64'd0);
        check("rst hilo_valid", 64'(hilo_valid), 64'd0);
        check("rst hilo_data", 64'(hilo_data), 64'd0);
        funct = F_MULT;
        repeat (2) @(posedge clk);
        #1;
        check("rst md_busy held", 64'(md_busy), 64'd0);
        issue = 1'b0;
        reset = 1'b0;
        issue_md("rst hi", F_MFHI, 0, 0);
        issue_md("rst lo", F_MFLO, 0, 0);

        vecs.push_back('{1'b0, 2'b00, 6'b101010, 4'h3, 4'b0010, 1'b0});
        vecs.push_back('{1'b0, 2'b01, 6'b011000, 4'h3, 4'b0110, 1'b0});
        vecs.push_back('{1'b0, 2'b11, 6'b100000, 4'h3, 4'b0000, 1'b1});
        vecs.push_back('{1'b1, 2'b10, 6'b100000, 4'b0101, 4'b0101, 1'b0});
        vecs.push_back('{1'b1, 2'b11, 6'b111111, 4'b1010, 4'b1010, 1'b0});
        for (int f = 0; f < 64; f++)
            vecs.push_back('{1'b0, 2'b10, 6'(f), 4'h9, exp_ctrl[f], exp_ill[f]});
        issue = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            inm = vecs[i].inm; alu_op = vecs[i].alu_op; funct = vecs[i].funct;
            alu_op_final = vecs[i].fin;
            #3;
            check($sformatf("dec%0d ctrl", i), 64'(control), 64'(vecs[i].e_ctrl));
            check($sformatf("dec%0d ill", i), 64'(illegal), 64'(vecs[i].e_ill));
        end
        @(posedge clk); #1;
        check("sweep no side effect", 64'(md_busy), 64'd0);

        // Signed multiply: WIDTH+1 busy cycles, sign-corrected 64-bit product.
        issue_md("mult -3*5", F_MULT, 32'hFFFF_FFFD, 32'd5);
        wait_idle(n);
        check("mult busy cycles", 64'(n), 64'd33);
        issue_md("mult lo", F_MFLO, 0, 0);
        issue_md("mult hi", F_MFHI, 0, 0);

        // MFHI two cycles behind MULTU: stalled until IDLE, then valid exactly once.
        issue_md("multu", F_MULTU, 32'hFFFF_FFFF, 32'd2);
        @(posedge clk); #1;
        issue = 1'b1; alu_op = 2'b10; inm = 1'b0; funct = F_MFHI;
        #3;
        n = 0;
        while (stall === 1'b1 && n < 100) begin
            n++;
            @(posedge clk); #4;
        end
        check("mfhi stall cycles", 64'(n), 64'd32);
        check("mfhi valid", 64'(hilo_valid), 64'd1);
        check("mfhi data", 64'(hilo_data), 64'(m_hi));
        @(posedge clk); #1;
        issue = 1'b0;
        #3;
        check("mfhi valid once", 64'(hilo_valid), 64'd0);
        check("mfhi no busy", 64'(md_busy), 64'd0);
        issue_md("multu lo", F_MFLO, 0, 0);

`ifdef ALU_CONTROL_MDU_DIV_EN
        issue_md("divu 100/7", F_DIVU, 32'd100, 32'd7);
        wait_idle(n);
        check("divu busy cycles", 64'(n), 64'd33);
        issue_md("divu lo", F_MFLO, 0, 0);
        issue_md("divu hi", F_MFHI, 0, 0);
        issue_md("div -7/2", F_DIV, 32'hFFFF_FFF9, 32'd2);
        issue_md("div lo", F_MFLO, 0, 0);
        issue_md("div hi", F_MFHI, 0, 0);
        issue_md("div 9/0", F_DIV, 32'd9, 32'd0);
        wait_idle(n);
        check("div0 busy cycles", 64'(n), 64'd1);
        issue_md("div0 lo", F_MFLO, 0, 0);
        issue_md("div0 hi", F_MFHI, 0, 0);
`else
        issue_md("div off", F_DIV, 32'd9, 32'd3);
        check("div off busy", 64'(md_busy), 64'd0);
        issue_md("divu off", F_DIVU, 32'd9, 32'd0);
        check("divu off busy", 64'(md_busy), 64'd0);
        issue_md("div off lo", F_MFLO, 0, 0);
        issue_md("div off hi", F_MFHI, 0, 0);
`endif

        // MD functs without issue, or on a non-R-type path, must not touch HI/LO.
        issue = 1'b0; alu_op = 2'b10; inm = 1'b0; funct = F_MTHI; rs_val = 32'hDEAD_0001;
        @(posedge clk); #1;
        issue = 1'b1; inm = 1'b1; funct = F_MTLO; rs_val = 32'hDEAD_0002;
        @(posedge clk); #1;
        issue = 1'b1; inm = 1'b0; alu_op = 2'b00; funct = F_MTHI;
        @(posedge clk); #1;
        issue = 1'b0;
        issue_md("gate hi", F_MFHI, 0, 0);
        issue_md("gate lo", F_MFLO, 0, 0);

        // Reset in the middle of a multiply aborts it; HI/LO return to zero.
        issue_md("mtlo 55", F_MTLO, 32'h55, 0);
        issue_md("mult 7*6", F_MULT, 32'd7, 32'd6);
        repeat (5) @(posedge clk);
        #1;
        issue = 1'b1; alu_op = 2'b10; inm = 1'b0; funct = F_MFHI;
        #2;
        check("pre-abort stall", 64'(stall), 64'd1);
        reset = 1'b1;
        #1;
        check("abort md_busy", 64'(md_busy), 64'd0);
        check("abort stall", 64'(stall), 64'd0);
        check("abort hilo_valid", 64'(hilo_valid), 64'd0);
        issue = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        repeat (3) @(posedge clk);
        #1;
        check("abort stays idle", 64'(md_busy), 64'd0);
        issue_md("abort hi", F_MFHI, 0, 0);
        issue_md("abort lo", F_MFLO, 0, 0);

        // Random back-to-back MD traffic; stalled instructions must execute exactly once.
        for (int i = 0; i < 40; i++) begin
            r_fn = md_fns[$urandom_range(7)];
            case ($urandom_range(3))
                0:       r_a = $urandom;
                1:       r_a = 32'h8000_0000;
                2:       r_a = 32'hFFFF_FFFF;
                default: r_a = $urandom_range(100);
            endcase
            case ($urandom_range(7))
                0:       r_b = 32'd0;
                1:       r_b = 32'hFFFF_FFFF;
                2:       r_b = $urandom_range(9);
                default: r_b = $urandom;
            endcase
            issue_md($sformatf("rnd%0d", i), r_fn, r_a, r_b);
            repeat ($urandom_range(3) == 0 ? $urandom_range(3) : 0) @(posedge clk);
        end
        issue_md("final hi", F_MFHI, 0, 0);
        issue_md("final lo", F_MFLO, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_control_mdu.md
ALU_CONTROL_MDU -- requirements
Module: alu_control_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width of operands and HI/LO (even, >=8).
REQ-002 SHALL have parameter CTRL_W, default 4, width of ALU control code.
REQ-003 SHALL have ports clk input 1 (rising-edge clock) and reset input 1 (reset, asynchronous, active-high); one clock.
REQ-004 SHALL have inputs inm 1 (immediate instruction), alu_op 2 (main-decoder class), funct 6 (R-type funct field), alu_op_final CTRL_W (immediate ALU code), issue 1 (instruction valid in EX this cycle), rs_val WIDTH and rt_val WIDTH (operands).
REQ-005 SHALL have outputs control CTRL_W (ALU code), illegal 1 (unrecognised funct), md_busy 1 (multiply/divide in progress), stall 1 (hold EX), hilo_data WIDTH (MFHI/MFLO result), hilo_valid 1 (hilo_data valid this cycle).

Function
REQ-006 control SHALL be combinational: inm=1 -> alu_op_final; alu_op 00 -> 0010; 01 -> 0110; 11 -> 0000, illegal=1.
REQ-007 alu_op=10 SHALL decode funct: 100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111, 100111->1100; MD funct (011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010000 MFHI, 010001 MTHI, 010010 MFLO, 010011 MTLO) -> 0000, illegal=0; any other funct -> 1111, illegal=1 (no latch inference).
REQ-008 illegal SHALL only be meaningful when issue=1; MD side effects SHALL occur only when issue=1, alu_op=10, inm=0, stall=0.
REQ-009 Sequencer states IDLE, BUSY, FIX; md_busy=1 in BUSY and FIX.
REQ-010 MULT/MULTU/DIV/DIVU accepted in IDLE: latch operands (signed ops use magnitudes plus recorded result signs), load counter=WIDTH, go BUSY next cycle.
REQ-011 BUSY SHALL perform one shift-add (multiply) or restoring shift-subtract (divide) step per cycle, decrement counter, go FIX after WIDTH steps.
REQ-012 FIX SHALL apply two's-complement sign correction (product sign = XOR of signs; quotient sign = XOR; remainder sign = dividend sign), write HI/LO at end of cycle, return IDLE; total md_busy = WIDTH+1 cycles.
REQ-013 MULT results: HI:LO = full 2*WIDTH product; DIV: LO = quotient truncated toward zero, HI = remainder.
REQ-014 Divide by zero SHALL skip BUSY: go straight to FIX, LO = all ones, HI = rs_val; md_busy for 1 cycle.
REQ-015 MTHI/MTLO in IDLE SHALL write rs_val to HI/LO at the clock edge.
REQ-016 MFHI/MFLO in IDLE SHALL drive hilo_data=HI/LO and hilo_valid=1 combinationally same cycle; otherwise hilo_data=0, hilo_valid=0.
REQ-017 stall SHALL be 1 combinationally while issue=1, the instruction is any MD funct, and state!=IDLE; non-MD instructions never stall.
REQ-018 A stalled instruction SHALL take effect in the first cycle state==IDLE (cycle after FIX), with no lost or duplicated operation.

Reset
REQ-019 reset SHALL force asynchronously: state=IDLE, counter=0, HI=0, LO=0, operand/accumulator registers=0, md_busy=0, stall=0, hilo_valid=0.
REQ-020 reset during BUSY/FIX SHALL abort the operation; HI/LO SHALL not receive partial results.

Configuration
REQ-021 Macro ALU_CONTROL_MDU_DIV_EN defined: DIV/DIVU implemented per REQ-010..014.
REQ-022 Macro undefined: no divider logic; DIV/DIVU decode as illegal=1, control=1111, no state change, HI/LO unchanged.

Structure
REQ-023 Shared package SHALL hold ALU codes (ADD, SUB, AND, OR, SLT, NOR, INVALID), funct constants, and the sequencer state enum.
REQ-024 Iterative datapath SHALL be sub-module mdu_iter (operands, start, op, step, result); decode and FSM stay in top.

Verification (WIDTH=32)
REQ-025 MULT rs=0xFFFFFFFD(-3), rt=5 -> md_busy 33 cycles, then LO=0xFFFFFFF1, HI=0xFFFFFFFF.
REQ-026 DIVU 100/7 -> LO=14, HI=2; DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-027 DIV 9/0 -> md_busy 1 cycle, LO=0xFFFFFFFF, HI=9.
REQ-028 MFHI issued 2 cycles after MULTU 0xFFFFFFFF*2 -> stall=1 until IDLE, then hilo_data=0x00000001, hilo_valid=1 once.
REQ-029 reset asserted mid-BUSY of MULT 7*6 following MTLO 0x55 -> HI=LO=0, state IDLE, md_busy=0 immediately.
REQ-030 Decode sweep: all 64 funct with alu_op=10, plus inm=1 alu_op_final=0101 -> control 0101, codes/illegal per REQ-006/007.
